// File: rtl/aes_req_arbiter_if.sv
// Requester, response and AES core signal bundle for aes_req_arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface aes_req_arbiter_if;
   logic         req0_valid;
   logic         req0_ready;
   logic [127:0] req0_data;
   logic [127:0] req0_key;
   logic         req1_valid;
   logic         req1_ready;
   logic [127:0] req1_data;
   logic [127:0] req1_key;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [127:0] rsp_data;
   logic         rsp_err;
   logic         core_en;
   logic [127:0] core_data_in;
   logic [127:0] core_key_in;
   logic [127:0] core_data_out;
   logic         core_data_out_valid;
   logic         busy;

   modport slave (
      input  req0_valid, req0_data, req0_key,
      input  req1_valid, req1_data, req1_key,
      input  rsp_ready, core_data_out, core_data_out_valid,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_err,
      output core_en, core_data_in, core_key_in, busy
   );

   modport master (
      output req0_valid, req0_data, req0_key,
      output req1_valid, req1_data, req1_key,
      output rsp_ready, core_data_out, core_data_out_valid,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_err,
      input  core_en, core_data_in, core_key_in, busy
   );
endinterface

// File: rtl/aes_req_arbiter.sv
// Round-robin two-requester sequencer in front of a single AES_top core.
// Optional macro AES_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a job with rsp_err.
module aes_req_arbiter #(
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic              AES_clk,
   input logic              AES_rst,
   aes_req_arbiter_if.slave bus
);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("aes_req_arbiter: GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
   end

   state_t           state_r, state_s;
   logic             last_r, last_s;
   logic             core_en_r, core_en_s;
   logic [127:0]     core_data_r, core_data_s;
   logic [127:0]     core_key_r, core_key_s;
   logic             rsp_id_r, rsp_id_s;
   logic [127:0]     rsp_data_r, rsp_data_s;
   logic             rsp_valid_r, rsp_valid_s;
   logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
   logic             grant_id_s;
   logic             grant_vld_s;
   logic             arb_open_s;
   logic             accept_s;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TMO_W   = (TMO_RAW > 7) ? TMO_RAW : 7;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

   logic             rsp_err_r, rsp_err_s;
   logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
   logic [TMO_W-1:0] tmo_inc_s;

   // Saturating count of BUSY cycles including the one now ending.
   assign tmo_inc_s = (tmo_cnt_r >= TMO_MAX) ? TMO_MAX : (tmo_cnt_r + TMO_W'(1));
`endif

   // Lone requester wins; a tie goes to the requester not served last.
   always_comb begin
      grant_id_s  = 1'b0;
      grant_vld_s = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_id_s  = ~last_r;
         grant_vld_s = 1'b1;
      end else if (bus.req0_valid) begin
         grant_id_s  = 1'b0;
         grant_vld_s = 1'b1;
      end else if (bus.req1_valid) begin
         grant_id_s  = 1'b1;
         grant_vld_s = 1'b1;
      end else begin
         grant_id_s  = 1'b0;
         grant_vld_s = 1'b0;
      end
   end

   // Ready is held low during reset so nothing is accepted on the release edge.
   assign arb_open_s     = (state_r == ST_IDLE) && !AES_rst;
   assign accept_s       = arb_open_s && grant_vld_s;
   assign bus.req0_ready = accept_s && !grant_id_s;
   assign bus.req1_ready = accept_s && grant_id_s;

   // Next-state and next-output logic of the job sequencer.
   always_comb begin
      state_s     = state_r;
      last_s      = last_r;
      core_en_s   = core_en_r;
      core_data_s = core_data_r;
      core_key_s  = core_key_r;
      rsp_id_s    = rsp_id_r;
      rsp_data_s  = rsp_data_r;
      rsp_valid_s = rsp_valid_r;
      gap_cnt_s   = gap_cnt_r;
`ifdef AES_ARB_TIMEOUT_EN
      rsp_err_s   = rsp_err_r;
      tmo_cnt_s   = tmo_cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               core_data_s = grant_id_s ? bus.req1_data : bus.req0_data;
               core_key_s  = grant_id_s ? bus.req1_key  : bus.req0_key;
               rsp_id_s    = grant_id_s;
               last_s      = grant_id_s;
               core_en_s   = 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
               tmo_cnt_s   = {TMO_W{1'b0}};
`endif
               state_s     = ST_BUSY;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (bus.core_data_out_valid) begin
               rsp_data_s  = bus.core_data_out;
               rsp_valid_s = 1'b1;
               core_en_s   = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
               rsp_err_s   = 1'b0;
`endif
               state_s     = ST_RESP;
`ifdef AES_ARB_TIMEOUT_EN
            end else if (tmo_inc_s >= TMO_MAX) begin
               rsp_data_s  = 128'd0;
               rsp_valid_s = 1'b1;
               rsp_err_s   = 1'b1;
               core_en_s   = 1'b0;
               tmo_cnt_s   = tmo_inc_s;
               state_s     = ST_RESP;
            end else begin
               tmo_cnt_s = tmo_inc_s;
               state_s   = ST_BUSY;
            end
`else
            end else begin
               state_s = ST_BUSY;
            end
`endif
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_s = 1'b0;
               gap_cnt_s   = GAP_LOAD;
               state_s     = ST_GAP;
            end else begin
               state_s = ST_RESP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == {GAP_W{1'b0}}) begin
               state_s = ST_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r - GAP_W'(1);
               state_s   = ST_GAP;
            end
         end
         default: begin
            core_en_s   = 1'b0;
            rsp_valid_s = 1'b0;
            state_s     = ST_IDLE;
         end
      endcase
   end

   // State and output registers; everything clears asynchronously, last points at req1.
   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         state_r     <= ST_IDLE;
         last_r      <= 1'b1;
         core_en_r   <= 1'b0;
         core_data_r <= 128'd0;
         core_key_r  <= 128'd0;
         rsp_id_r    <= 1'b0;
         rsp_data_r  <= 128'd0;
         rsp_valid_r <= 1'b0;
         gap_cnt_r   <= {GAP_W{1'b0}};
`ifdef AES_ARB_TIMEOUT_EN
         rsp_err_r   <= 1'b0;
         tmo_cnt_r   <= {TMO_W{1'b0}};
`endif
      end else begin
         state_r     <= state_s;
         last_r      <= last_s;
         core_en_r   <= core_en_s;
         core_data_r <= core_data_s;
         core_key_r  <= core_key_s;
         rsp_id_r    <= rsp_id_s;
         rsp_data_r  <= rsp_data_s;
         rsp_valid_r <= rsp_valid_s;
         gap_cnt_r   <= gap_cnt_s;
`ifdef AES_ARB_TIMEOUT_EN
         rsp_err_r   <= rsp_err_s;
         tmo_cnt_r   <= tmo_cnt_s;
`endif
      end
   end

   assign bus.core_en      = core_en_r;
   assign bus.core_data_in = core_data_r;
   assign bus.core_key_in  = core_key_r;
   assign bus.rsp_id       = rsp_id_r;
   assign bus.rsp_data     = rsp_data_r;
   assign bus.rsp_valid    = rsp_valid_r;
   assign bus.busy         = (state_r != ST_IDLE);
`ifdef AES_ARB_TIMEOUT_EN
   assign bus.rsp_err      = rsp_err_r;
`else
   assign bus.rsp_err      = 1'b0;
`endif
endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized bench for aes_req_arbiter with a stub AES core and a job-level reference model.
// Timeout jobs are exercised only when AES_ARB_TIMEOUT_EN is defined.
module tb_aes_req_arbiter;
   localparam int GAP = 2;
   localparam int TMO = 64;
   localparam logic [127:0] SALT = 128'h3c5a_96e1_0f1e_2d3c_4b5a_6978_8796_a5b4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   aes_req_arbiter_if bus();

   aes_req_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .AES_clk (clk),
      .AES_rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Stub core: pulses valid so that core_en stays high exactly stub_lat cycles.
   int           stub_lat  = 2;
   bit           stub_mute = 1'b0;
   int           stub_cnt;
   logic         stub_vld;
   logic [127:0] stub_out;
   logic         spur = 1'b0;
   logic [127:0] junk = 128'd0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_cnt <= 0;
         stub_vld <= 1'b0;
         stub_out <= 128'd0;
      end else begin
         stub_vld <= 1'b0;
         if (bus.core_en) begin
            stub_cnt <= stub_cnt + 1;
            if (!stub_mute && (stub_cnt + 1 == stub_lat - 1)) begin
               stub_vld <= 1'b1;
               stub_out <= bus.core_data_in ^ bus.core_key_in ^ SALT;
            end
         end else begin
            stub_cnt <= 0;
         end
      end
   end

   assign bus.core_data_out_valid = stub_vld | spur;
   assign bus.core_data_out       = spur ? junk : stub_out;

   int total = 0;
   int bad   = 0;
   int low_cnt = 0;
   bit have_prev = 1'b0;
   int m_last = 1;
   logic [127:0] d0, k0, d1, k1;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Advance to the next falling edge and track how long core_en has been low.
   task automatic step();
      @(negedge clk);
      if (bus.core_en) low_cnt = 0;
      else low_cnt++;
   endtask

   // One complete job: arbitration, BUSY, optional back-pressure, handshake, GAP.
   task automatic do_job(input bit v0, input bit v1, input int lat, input int hold,
                         input bit mute, input bit fixed);
      int           exp_id;
      logic [127:0] ed, ek, exp_data;
      logic         exp_err;
      int           hi, g;
      bit           ok;
      logic         cv_last;
      if (!fixed) begin
         d0 = rnd128(); k0 = rnd128();
      end
      d1 = rnd128(); k1 = rnd128();
      bus.req0_valid = v0; bus.req0_data = d0; bus.req0_key = k0;
      bus.req1_valid = v1; bus.req1_data = d1; bus.req1_key = k1;
      bus.rsp_ready  = 1'b0;
      stub_lat  = lat;
      stub_mute = mute;
      exp_id   = (v0 && v1) ? (1 - m_last) : (v1 ? 1 : 0);
      ed       = (exp_id == 1) ? d1 : d0;
      ek       = (exp_id == 1) ? k1 : k0;
      exp_data = mute ? 128'd0 : (ed ^ ek ^ SALT);
      exp_err  = mute;
      #1;
      check_eq("ready0", bus.req0_ready, (exp_id == 0));
      check_eq("ready1", bus.req1_ready, (exp_id == 1));
      if (have_prev) check_eq("en_low_gap", (low_cnt >= GAP + 1), 1'b1);
      step();
      m_last = exp_id;
      have_prev = 1'b1;
      check_eq("en_on", bus.core_en, 1'b1);
      check_eq("core_data", bus.core_data_in, ed);
      check_eq("core_key", bus.core_key_in, ek);
      hi = 0; ok = 1'b1; cv_last = 1'b0;
      while (bus.core_en === 1'b1 && hi < 400) begin
         hi++;
         if (bus.core_data_in !== ed || bus.core_key_in !== ek) ok = 1'b0;
         if (bus.req0_ready || bus.req1_ready || bus.rsp_valid || !bus.busy) ok = 1'b0;
         cv_last = bus.core_data_out_valid;
         step();
      end
      check_eq("en_cycles", hi, mute ? TMO : lat);
      check_eq("busy_stable", ok, 1'b1);
      if (!mute) check_eq("rsp_after_cv", cv_last, 1'b1);
      check_eq("rsp_valid", bus.rsp_valid, 1'b1);
      check_eq("rsp_id", bus.rsp_id, exp_id[0]);
      check_eq("rsp_data", bus.rsp_data, exp_data);
      check_eq("rsp_err", bus.rsp_err, exp_err);
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step();
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id[0] || bus.rsp_data !== exp_data ||
             bus.rsp_err !== exp_err || bus.req0_ready || bus.req1_ready || bus.core_en)
            ok = 1'b0;
      end
      if (hold > 0) check_eq("backpressure", ok, 1'b1);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check_eq("rsp_drop", bus.rsp_valid, 1'b0);
      g = 0; ok = 1'b1;
      while (bus.busy === 1'b1 && g < 50) begin
         if (bus.req0_ready || bus.req1_ready || bus.rsp_valid || bus.core_en) ok = 1'b0;
         spur = 1'($urandom_range(0, 1));
         junk = rnd128();
         step();
         g++;
      end
      spur = 1'b0;
      check_eq("gap_quiet", ok, 1'b1);
      check_eq("gap_len", g, GAP);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   initial begin
      bit ok;
      bus.req0_valid = 1'b1; bus.req0_data = 128'd0; bus.req0_key = 128'd0;
      bus.req1_valid = 1'b1; bus.req1_data = 128'd0; bus.req1_key = 128'd0;
      bus.rsp_ready  = 1'b0;
      rst = 1'b1;
      step();
      step();
      check_eq("rst_ready0", bus.req0_ready, 1'b0);
      check_eq("rst_ready1", bus.req1_ready, 1'b0);
      check_eq("rst_en", bus.core_en, 1'b0);
      check_eq("rst_busy", bus.busy, 1'b0);
      check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check_eq("rst_rsp_data", bus.rsp_data, 128'd0);
      check_eq("rst_rsp_err", bus.rsp_err, 1'b0);
      check_eq("rst_core_data", bus.core_data_in, 128'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rst = 1'b0;
      step();

      // Tied requests from reset: expected grant order 0,1,0,1.
      for (int i = 0; i < 4; i++) begin
         do_job(1'b1, 1'b1, $urandom_range(2, 12), 0, 1'b0, 1'b0);
         check_eq("tie_order", m_last, i % 2);
      end

      d0 = 128'h000000f0_00000000_00000000_00000000;
      k0 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
      do_job(1'b1, 1'b0, 50, 0, 1'b0, 1'b1);

      do_job(1'b0, 1'b1, 6, 10, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         int pat;
         pat = $urandom_range(1, 3);
         do_job(pat[0], pat[1], $urandom_range(2, 20), $urandom_range(0, 5), 1'b0, 1'b0);
      end

      // Spurious core valid while IDLE with nobody requesting.
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         spur = 1'b1;
         junk = rnd128();
         step();
         if (bus.busy || bus.rsp_valid || bus.core_en) ok = 1'b0;
      end
      spur = 1'b0;
      check_eq("idle_spurious", ok, 1'b1);

      // Reset in the middle of BUSY.
      bus.req0_valid = 1'b1; bus.req0_data = rnd128(); bus.req0_key = rnd128();
      bus.req1_valid = 1'b1; bus.req1_data = rnd128(); bus.req1_key = rnd128();
      stub_lat = 40;
      step();
      check_eq("pre_rst_en", bus.core_en, 1'b1);
      for (int i = 0; i < 10; i++) step();
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_en", bus.core_en, 1'b0);
      check_eq("async_busy", bus.busy, 1'b0);
      check_eq("async_rsp_valid", bus.rsp_valid, 1'b0);
      check_eq("async_ready0", bus.req0_ready, 1'b0);
      step();
      step();
      rst = 1'b0;
      m_last = 1;
      have_prev = 1'b0;
      do_job(1'b1, 1'b1, 5, 0, 1'b0, 1'b0);
      check_eq("post_rst_tie", m_last, 0);

`ifdef AES_ARB_TIMEOUT_EN
      do_job(1'b1, 1'b0, 5, 2, 1'b1, 1'b0);
      do_job(1'b0, 1'b1, 7, 0, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
